pwm_gen: RTL and testbench
==========================

Name: pwm_gen

Overview:
Single-channel PWM generator that consumes the 8-bit frequency-divider and duty values from the AXI4-Lite register block and drives one servo/motor PWM pin. A prescaler divides the clock; an 8-bit phase counter forms the PWM period. Divider and duty are shadowed and reloaded only at period boundaries so the output never glitches. Enable removal drains the current period before the block goes idle.

Parameters:
C_DIV_W, 8, width of frequency-divider input and prescaler counter
C_DUTY_W, 8, width of duty input and phase counter (period = 2^C_DUTY_W phases)

Ports:
s_axi_aclk  in  1  clock, same domain as register block
s_axi_areset  in  1  synchronous, active-high reset
pwm_en  in  1  run request, level
pwm_freq_div  in  C_DIV_W  prescale value; phase advances every (div+1) clocks
pwm_duty  in  C_DUTY_W  high phases per period
pwm_out  out  1  PWM output, registered
pwm_period_strb  out  1  one-cycle pulse on first cycle of each new period
pwm_active  out  1  high when state is RUN or DRAIN

Behaviour:
- Reset: state=IDLE, pre=0, phase=0, div_sh=0, duty_sh=0, pwm_out=0, pwm_period_strb=0, pwm_active=0. Reset wins over all other inputs, including mid-period; outputs reach reset values on the same edge.
- All outputs are flops. pre, phase, shadows, state and outputs update on the same edge, so pwm_out is high exactly on cycles where state is RUN or DRAIN and phase < duty_sh.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: pwm_out=0, counters held at 0. pwm_en=1 sampled triggers the following on the next edge: div_sh<=pwm_freq_div, duty_sh<=pwm_duty, pre=0, phase=0, state=RUN, pwm_period_strb=1, pwm_out=(pwm_duty!=0). Latency from pwm_en to the first high output is 1 clock.
- Prescaler in RUN/DRAIN: a tick occurs on cycles where pre==div_sh; pre then returns to 0, otherwise pre increments. div_sh=0 gives a tick every clock.
- Tick with phase < 2^C_DUTY_W-1: phase increments.
- Tick with phase == 2^C_DUTY_W-1 (period end):
  - In RUN with pwm_en=1: phase wraps to 0, shadows reload from inputs, pwm_period_strb=1 for one cycle.
  - In RUN with pwm_en=0: same as DRAIN below.
- RUN with pwm_en=0 goes to DRAIN on the next edge. Counting continues unchanged and the output does not glitch.
- DRAIN with pwm_en=1 returns to RUN with no counter disturbance.
- DRAIN at period end: goes to IDLE, phase=0, pre=0, pwm_out=0, no strobe.
- Period length is (div_sh+1)*2^C_DUTY_W clocks. High time is duty_sh*(div_sh+1) clocks.
- duty_sh=0 gives a constant low output. duty_sh=2^C_DUTY_W-1 gives high for all phases but the last; 100% duty is not possible by design.
- Input changes mid-period are ignored until the next period boundary. pwm_freq_div and pwm_duty are treated as stable quasi-static register outputs, with no CDC.
- Arithmetic is unsigned. Counters wrap modulo their widths only at the stated boundaries, with no overflow beyond them.

Test Plan:
- Basic period: reset, div=0, duty=64, en=1 → strobe 1 clk after en. Period is 256 clks with pwm_out high 64 clks then low 192; strobes are spaced exactly 256 clks apart.
- Prescale: div=3, duty=128 → period 1024 clks, high 512 clks. pre is observed cycling 0..3.
- Shadow update: div=0, duty=32; write duty=200 at phase 100 → the current period stays high 32 clks. The next period after the strobe is high 200 clks.
- Extremes: duty=0 → pwm_out stays 0 for 3 periods while strobes still pulse. duty=255, div=0 → high 255 clks, low 1 clk per period.
- Graceful stop and resume:
  - Drop en at phase 50 → output continues to period end, then pwm_active falls, pwm_out=0, no strobe at that boundary.
  - Repeat, but reassert en during DRAIN → the period boundary produces a strobe and running continues without a gap.
- Reset mid-run: assert s_axi_areset for 1 clk at phase 10 with pwm_out high → pwm_out=0, pwm_active=0, strobe=0 the next cycle. With en held high, the block restarts with a strobe 1 clk after reset release.

Source files
------------

// File: rtl/pwm_gen_if.sv
// rtl/pwm_gen_if.sv - control and status bundle between the register block and the PWM generator
interface pwm_gen_if #(
  parameter int C_DIV_W  = 8,
  parameter int C_DUTY_W = 8
) ();

  logic                pwm_en;
  logic [C_DIV_W-1:0]  pwm_freq_div;
  logic [C_DUTY_W-1:0] pwm_duty;
  logic                pwm_out;
  logic                pwm_period_strb;
  logic                pwm_active;

  // Register block side: owns the run request and the quasi-static settings
  modport master (
    output pwm_en,
    output pwm_freq_div,
    output pwm_duty,
    input  pwm_out,
    input  pwm_period_strb,
    input  pwm_active
  );

  // Generator side
  modport slave (
    input  pwm_en,
    input  pwm_freq_div,
    input  pwm_duty,
    output pwm_out,
    output pwm_period_strb,
    output pwm_active
  );

endinterface

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - single-channel PWM generator with shadowed divider/duty and draining stop
module pwm_gen #(
  parameter int C_DIV_W  = 8,
  parameter int C_DUTY_W = 8
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_areset,
  pwm_gen_if.slave   pwm
);

  // Last phase of a period; the period is 2^C_DUTY_W phases long
  localparam logic [C_DUTY_W-1:0] PHASE_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [C_DIV_W-1:0]  pre_q, pre_d;
  logic [C_DIV_W-1:0]  div_sh_q, div_sh_d;
  logic [C_DUTY_W-1:0] phase_q, phase_d;
  logic [C_DUTY_W-1:0] duty_sh_q, duty_sh_d;
  logic                out_q, out_d;
  logic                strb_q, strb_d;
  logic                active_q, active_d;

  logic                tick;
  logic                period_end;

  // Prescaler tick and period boundary, both from the shadowed divider
  always_comb begin
    tick       = (pre_q == div_sh_q);
    period_end = tick && (phase_q == PHASE_LAST);
  end

  // Next state, counters, shadows and output values; outputs are derived from
  // the next-state values so they line up with the registered counters
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    phase_d   = phase_q;
    div_sh_d  = div_sh_q;
    duty_sh_d = duty_sh_q;
    strb_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pre_d   = '0;
        phase_d = '0;
        if (pwm.pwm_en) begin
          state_d   = ST_RUN;
          div_sh_d  = pwm.pwm_freq_div;
          duty_sh_d = pwm.pwm_duty;
          strb_d    = 1'b1;
        end
      end

      ST_RUN, ST_DRAIN: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (period_end) begin
          phase_d = '0;
          if ((state_q == ST_RUN) && pwm.pwm_en) begin
            // Only place the shadows are allowed to change while running
            state_d   = ST_RUN;
            div_sh_d  = pwm.pwm_freq_div;
            duty_sh_d = pwm.pwm_duty;
            strb_d    = 1'b1;
          end else begin
            // Stop request seen: finish cleanly at the boundary, no strobe
            state_d = ST_IDLE;
            pre_d   = '0;
          end
        end else begin
          if (tick) begin
            phase_d = phase_q + 1'b1;
          end
          // Dropping or restoring enable only flips the state; counting carries on
          state_d = pwm.pwm_en ? ST_RUN : ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pre_d   = '0;
        phase_d = '0;
      end
    endcase

    active_d = (state_d != ST_IDLE);
    out_d    = active_d && (phase_d < duty_sh_d);
  end

  // State, counters, shadows and output flops all advance on the same edge
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      phase_q   <= '0;
      div_sh_q  <= '0;
      duty_sh_q <= '0;
      out_q     <= 1'b0;
      strb_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      phase_q   <= phase_d;
      div_sh_q  <= div_sh_d;
      duty_sh_q <= duty_sh_d;
      out_q     <= out_d;
      strb_q    <= strb_d;
      active_q  <= active_d;
    end
  end

  assign pwm.pwm_out         = out_q;
  assign pwm.pwm_period_strb = strb_q;
  assign pwm.pwm_active      = active_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen against a period-arithmetic reference model
module tb_pwm_gen;

  localparam int DW  = 8;
  localparam int UW  = 8;
  localparam int NPH = 1 << UW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a period is (div+1)*NPH clocks; k counts clocks since period start
  bit m_run     = 1'b0;
  bit m_en_last = 1'b0;
  int m_k       = 0;
  int m_div     = 0;
  int m_duty    = 0;
  bit e_out     = 1'b0;
  bit e_strb    = 1'b0;

  // Free-running clock
  always #5 clk = ~clk;

  pwm_gen_if #(.C_DIV_W(DW), .C_DUTY_W(UW)) pif ();

  pwm_gen #(.C_DIV_W(DW), .C_DUTY_W(UW)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .pwm          (pif.slave)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  // Advance one clock, update the model from the inputs present at the edge, then check
  task automatic tick();
    bit r, en;
    int dv, dt, plen;
    r  = rst;
    en = pif.pwm_en;
    dv = int'(pif.pwm_freq_div);
    dt = int'(pif.pwm_duty);
    @(posedge clk);
    if (r) begin
      m_run = 0; m_k = 0; m_en_last = 0; e_strb = 0;
    end else if (!m_run) begin
      e_strb = 0;
      if (en) begin
        m_run = 1; m_k = 0; m_div = dv; m_duty = dt; e_strb = 1;
      end
      m_en_last = en;
    end else begin
      plen   = (m_div + 1) * NPH;
      e_strb = 0;
      if (m_k == plen - 1) begin
        if (en && m_en_last) begin
          m_k = 0; m_div = dv; m_duty = dt; e_strb = 1;
        end else begin
          m_run = 0; m_k = 0;
        end
      end else begin
        m_k++;
      end
      m_en_last = en;
    end
    e_out = m_run && ((m_k / (m_div + 1)) < m_duty);
    #1;
    chk("model_out", int'(pif.pwm_out), int'(e_out));
    chk("model_strb", int'(pif.pwm_period_strb), int'(e_strb));
    chk("model_active", int'(pif.pwm_active), int'(m_run));
  endtask

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pif.pwm_period_strb && n < budget);
    chk("strobe_timeout", int'(pif.pwm_period_strb), 1);
  endtask

  // Called on a strobe cycle; counts the period length and high cycles up to the next strobe
  task automatic measure(input int chg_at, input int chg_duty, output int len, output int high);
    len  = 1;
    high = int'(pif.pwm_out);
    for (int i = 1; i < 4000; i++) begin
      if (i == chg_at) pif.pwm_duty = chg_duty[UW-1:0];
      tick();
      if (pif.pwm_period_strb) break;
      len++;
      high += int'(pif.pwm_out);
    end
  endtask

  // Directed and randomized sequence
  initial begin
    int n, len, high, seen, gap;
    pif.pwm_en       = 1'b0;
    pif.pwm_freq_div = '0;
    pif.pwm_duty     = '0;

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_out", int'(pif.pwm_out), 0);
    chk("reset_strb", int'(pif.pwm_period_strb), 0);
    chk("reset_active", int'(pif.pwm_active), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic period
    pif.pwm_freq_div = 8'd0;
    pif.pwm_duty     = 8'd64;
    pif.pwm_en       = 1'b1;
    wait_strobe(5, n);
    chk("start_latency", n, 1);
    chk("start_out", int'(pif.pwm_out), 1);
    measure(-1, 0, len, high);
    chk("basic_len", len, 256);
    chk("basic_high", high, 64);
    measure(-1, 0, len, high);
    chk("basic_spacing", len, 256);

    // Prescale
    pif.pwm_freq_div = 8'd3;
    pif.pwm_duty     = 8'd128;
    wait_strobe(300, n);
    measure(-1, 0, len, high);
    chk("presc_len", len, 1024);
    chk("presc_high", high, 512);

    // Shadow update mid-period
    pif.pwm_freq_div = 8'd0;
    pif.pwm_duty     = 8'd32;
    wait_strobe(1100, n);
    measure(100, 200, len, high);
    chk("shadow_cur_len", len, 256);
    chk("shadow_cur_high", high, 32);
    measure(-1, 0, len, high);
    chk("shadow_next_high", high, 200);

    // Extremes
    pif.pwm_duty = 8'd0;
    wait_strobe(300, n);
    for (int p = 0; p < 3; p++) begin
      measure(-1, 0, len, high);
      chk("duty0_len", len, 256);
      chk("duty0_high", high, 0);
    end
    pif.pwm_duty = 8'd255;
    wait_strobe(300, n);
    measure(-1, 0, len, high);
    chk("duty255_len", len, 256);
    chk("duty255_high", high, 255);

    // Graceful stop
    pif.pwm_duty = 8'd100;
    wait_strobe(300, n);
    repeat (50) tick();
    pif.pwm_en = 1'b0;
    n = 0;
    seen = 0;
    do begin
      tick();
      n++;
      if (pif.pwm_period_strb) seen = 1;
    end while (pif.pwm_active && n < 400);
    chk("drain_cycles", n, 206);
    chk("drain_no_strobe", seen, 0);
    chk("drain_out_low", int'(pif.pwm_out), 0);

    // Stop then resume during drain
    pif.pwm_en = 1'b1;
    wait_strobe(5, n);
    chk("restart_latency", n, 1);
    repeat (50) tick();
    pif.pwm_en = 1'b0;
    repeat (20) tick();
    chk("drain_active", int'(pif.pwm_active), 1);
    pif.pwm_en = 1'b1;
    n = 0;
    gap = 0;
    do begin
      tick();
      n++;
      if (!pif.pwm_active) gap = 1;
    end while (!pif.pwm_period_strb && n < 400);
    chk("resume_cycles", n, 186);
    chk("resume_no_gap", gap, 0);

    // Randomized settings and enable toggling
    for (int r = 0; r < 6; r++) begin
      pif.pwm_freq_div = 8'($urandom_range(0, 3));
      pif.pwm_duty     = 8'($urandom_range(0, 255));
      pif.pwm_en       = ($urandom_range(0, 3) != 0);
      n = $urandom_range(50, 1200);
      repeat (n) tick();
    end

    // Reset mid-run
    pif.pwm_freq_div = 8'd0;
    pif.pwm_duty     = 8'd64;
    pif.pwm_en       = 1'b1;
    wait_strobe(2000, n);
    repeat (10) tick();
    chk("pre_reset_out", int'(pif.pwm_out), 1);
    rst = 1'b1;
    tick();
    chk("midrst_out", int'(pif.pwm_out), 0);
    chk("midrst_active", int'(pif.pwm_active), 0);
    chk("midrst_strb", int'(pif.pwm_period_strb), 0);
    rst = 1'b0;
    tick();
    chk("post_reset_strb", int'(pif.pwm_period_strb), 1);
    chk("post_reset_out", int'(pif.pwm_out), 1);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
